// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full_adder cell, LSB first.
//
// Adds two WIDTH-bit operands plus a carry-in, one bit per clock, holding
// the inter-bit carry in a flop. A request is accepted in IDLE or DONE,
// RUN lasts WIDTH cycles, and DONE pulses done for one cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted in IDLE or DONE, ignored in RUN
//   a, b   - operands, captured on the accept edge
//   c_in   - carry-in, captured on the accept edge
//   busy   - high while in RUN
//   done   - one-cycle result-valid pulse
//   sum    - result, held from done until the next accepted start
//   c_out  - final carry-out, same validity as sum
//   ovf    - signed overflow flag (0 unless SERIAL_ADDER_OVERFLOW_EN)
//
// Build option: define SERIAL_ADDER_OVERFLOW_EN to compute ovf as
// (carry into MSB) XOR (carry out of MSB); otherwise ovf is tied to 0.

// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    // Counter holds 0..WIDTH-1 with headroom, so it never wraps.
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shift_c;
    logic               last_bit_c;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
    if (WIDTH == 1) begin : g_sum_w1
        assign sum_shift_c = fa_sum;
    end else begin : g_sum_wn
        assign sum_shift_c = {fa_sum, sum[WIDTH-1:1]};
    end

    assign last_bit_c = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        sum   <= '0;
                        c_out <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum   <= sum_shift_c;
                    carry <= fa_cout;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        c_out <= fa_cout;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    // On the MSB step the carry flop holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            ovf <= 1'b0;
        end else if (last_bit_c) begin
            ovf <= carry ^ fa_cout;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
